fpu_dp_divider: RTL and testbench

FPU_DP_DIVIDER -- requirements
Module: fpu_dp_divider

---
 rtl/fpu_dp_pkg.sv | 9 +
 rtl/fpu_dp_rounder.sv | 34 +++
 rtl/fpu_dp_divider.sv | 99 +++++++++
 tb/tb_fpu_dp_divider.sv | 118 +++++++++++
 4 files changed

// File: rtl/fpu_dp_pkg.sv
// fpu_dp_pkg: shared binary64 field widths, special constants and divider states
package fpu_dp_pkg;
  localparam int EXP_BIAS = 1023;
  localparam int EXP_W = 11;
  localparam int MANT_W = 52;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;
  localparam logic [63:0] INF = 64'h7FF0000000000000;
  typedef enum logic [2:0] {IDLE, UNPACK, DIV, ROUND, DONE} div_state_t;
endpackage

// File: rtl/fpu_dp_rounder.sv
// fpu_dp_rounder: normalise, round (RNE when FPU_DP_DIV_RNE_EN, else truncate) and pack a 55-bit quotient
module fpu_dp_rounder
  import fpu_dp_pkg::*;
(
  input  logic               sign,
  input  logic signed [12:0] exp,
  input  logic [54:0]        q,
  input  logic               sticky,
  output logic [63:0]        result
);
  logic norm, g, rs, inc, unused_bits;
  logic [MANT_W:0] mant;
  logic [MANT_W+1:0] sum;
  logic signed [12:0] e, ef;
  always_comb begin
    norm = ~q[54];
    mant = norm ? q[53:1] : q[54:2];
    g = norm ? q[0] : q[1];
    rs = norm ? sticky : (q[0] | sticky);
`ifdef FPU_DP_DIV_RNE_EN
    inc = g & (rs | mant[0]);
`else
    inc = 1'b0;
`endif
    sum = {1'b0, mant} + {{MANT_W + 1{1'b0}}, inc};
    e = exp - $signed({12'b0, norm});
    // a carry out of rounding leaves the fraction all-zero, so only the exponent moves
    ef = e + $signed({12'b0, sum[MANT_W+1]});
    result = ef >= 13'sd2047 ? {sign, INF[62:0]} :
             ef <= 13'sd0 ? {sign, 63'b0} :
             {sign, ef[EXP_W-1:0], sum[MANT_W-1:0]};
    unused_bits = sum[MANT_W] ^ g ^ rs;
  end
endmodule

// File: rtl/fpu_dp_divider.sv
// fpu_dp_divider: multi-cycle binary64 divider, radix-2 restoring, flush-to-zero.
// FPU_DP_DIV_RNE_EN selects round-to-nearest-even; otherwise results truncate.
module fpu_dp_divider
  import fpu_dp_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             invalid
);
  div_state_t state, next;
  logic [63:0] a_r, b_r, spec_res, rounded;
  logic [EXP_W-1:0] ea, eb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn, special, spec_inv, spec_dbz, ge;
  logic [5:0] cnt;
  logic sign;
  logic signed [12:0] exp;
  logic [MANT_W:0] mb;
  logic [54:0] rem, q, sub;
  always_comb begin
    ea = a_r[62:52];
    eb = b_r[62:52];
    a_nan = &ea & |a_r[51:0];
    b_nan = &eb & |b_r[51:0];
    a_inf = &ea & ~|a_r[51:0];
    b_inf = &eb & ~|b_r[51:0];
    a_zero = ~|ea;
    b_zero = ~|eb;
    sgn = a_r[63] ^ b_r[63];
    special = a_zero | b_zero | (&ea) | (&eb);
    spec_inv = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    spec_dbz = ~spec_inv & ~a_inf & b_zero;
    spec_res = spec_inv ? QNAN : (a_inf | b_zero) ? {sgn, INF[62:0]} : {sgn, 63'b0};
    ge = rem >= {2'b0, mb};
    sub = rem - {2'b0, mb};
    next = state == IDLE ? (in_valid ? UNPACK : IDLE) :
           state == UNPACK ? (special ? DONE : DIV) :
           state == DIV ? (cnt == 6'd54 ? ROUND : DIV) :
           state == ROUND ? DONE : (out_ready ? IDLE : DONE);
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  fpu_dp_rounder u_rounder (
    .sign(sign),
    .exp(exp),
    .q(q),
    .sticky(|rem),
    .result(rounded)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      result <= '0;
      div_by_zero <= 1'b0;
      invalid <= 1'b0;
    end else begin
      state <= next;
      cnt <= state == DIV ? cnt + 6'd1 : '0;
      if (state == UNPACK && special) begin
        result <= spec_res;
        div_by_zero <= spec_dbz;
        invalid <= spec_inv;
      end
      if (state == ROUND) begin
        result <= rounded;
        div_by_zero <= 1'b0;
        invalid <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= b;
    end
    if (state == UNPACK) begin
      sign <= sgn;
      exp <= $signed({2'b0, ea}) - $signed({2'b0, eb}) + 13'sd1023;
      rem <= {2'b0, 1'b1, a_r[MANT_W-1:0]};
      mb <= {1'b1, b_r[MANT_W-1:0]};
      q <= '0;
    end
    // one quotient bit per cycle; the partial remainder always stays below 2*mb
    if (state == DIV) begin
      rem <= (ge ? sub : rem) << 1;
      q <= {q[53:0], ge};
    end
  end
endmodule

// File: tb/tb_fpu_dp_divider.sv
// tb_fpu_dp_divider: directed vector table plus hold/abort sequences for fpu_dp_divider
module tb_fpu_dp_divider;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [63:0] a = 0, b = 0, result;
  logic in_ready, out_valid, div_by_zero, invalid;
  int tests = 0, fails = 0;
  typedef struct {
    logic [63:0] a, b, res;
    logic dbz, inv;
    int lat;
  } vec_t;
  vec_t vt[$];
  fpu_dp_divider #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .div_by_zero(div_by_zero), .invalid(invalid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic start(input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    chk("in_ready_before_start", {63'b0, in_ready}, 64'd1);
    a = x;
    b = y;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    start(v.a, v.b);
    wait_valid(lat);
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d_result", idx), result, v.res);
    chk($sformatf("v%0d_dbz", idx), {63'b0, div_by_zero}, {63'b0, v.dbz});
    chk($sformatf("v%0d_invalid", idx), {63'b0, invalid}, {63'b0, v.inv});
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk($sformatf("v%0d_after_consume", idx), {62'b0, out_valid, in_ready}, 64'b01);
  endtask
  initial begin
    int lat;
    logic seen;
    vt.push_back('{64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 0, 0, 58});
`ifdef FPU_DP_DIV_RNE_EN
    vt.push_back('{64'h3FF0000000000000, 64'h4024000000000000, 64'h3FB999999999999A, 0, 0, 58});
`else
    vt.push_back('{64'h3FF0000000000000, 64'h4024000000000000, 64'h3FB9999999999999, 0, 0, 58});
`endif
    vt.push_back('{64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 1, 0, 2});
    vt.push_back('{64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 0, 1, 2});
    vt.push_back('{64'hC01999999999999A, 64'hBFE0000000000000, 64'h402999999999999A, 0, 0, 58});
    vt.push_back('{64'h7FF8000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 0, 1, 2});
    vt.push_back('{64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000, 0, 1, 2});
    vt.push_back('{64'hFFF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, 0, 0, 2});
    vt.push_back('{64'h8000000000000000, 64'h4014000000000000, 64'h8000000000000000, 0, 0, 2});
    vt.push_back('{64'h4008000000000000, 64'h7FF0000000000000, 64'h0000000000000000, 0, 0, 2});
    vt.push_back('{64'hBFF0000000000000, 64'h0000000000000000, 64'hFFF0000000000000, 1, 0, 2});
    vt.push_back('{64'h7FEFFFFFFFFFFFFF, 64'h3CB0000000000000, 64'h7FF0000000000000, 0, 0, 58});
    vt.push_back('{64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 0, 0, 58});
    vt.push_back('{64'h0000000000000001, 64'h3FF0000000000000, 64'h0000000000000000, 0, 0, 2});
    vt.push_back('{64'h3FF0000000000000, 64'h000FFFFFFFFFFFFF, 64'h7FF0000000000000, 1, 0, 2});
    vt.push_back('{64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 0, 0, 58});
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_flags", {62'b0, div_by_zero, invalid}, 64'd0);
    foreach (vt[i]) run_vec(vt[i], i);
    start(64'h4018000000000000, 64'h4000000000000000);
    wait_valid(lat);
    chk("hold_latency", 64'(lat), 64'd58);
    a = 64'h3FF0000000000000;
    b = 64'h4024000000000000;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d_result", i), result, 64'h4008000000000000);
      chk($sformatf("hold%0d_hs", i), {62'b0, out_valid, in_ready}, 64'b10);
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("hold_release", {62'b0, out_valid, in_ready}, 64'b01);
    start(64'h3FF0000000000000, 64'h4024000000000000);
    repeat (20) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_in_ready", {63'b0, in_ready}, 64'd1);
    chk("abort_result", result, 64'd0);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("abort_no_valid", {63'b0, seen}, 64'd0);
    run_vec(vt[4], 100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
